// File: rtl/pulse_stretcher_bank.sv
// Bank of independent pulse stretchers with shared hold length and sticky edge flags.
// Optional input synchronizer: define PULSE_STRETCHER_BANK_SYNC_EN.
module pulse_stretcher_bank #(
    parameter int CHANNELS  = 4,
    parameter int BITS      = 20,
    parameter int RETRIGGER = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    input  logic [BITS-1:0]     hold,
    input  logic                clear,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] sticky,
    output logic                any_active
);

    logic [CHANNELS-1:0] src;

`ifdef PULSE_STRETCHER_BANK_SYNC_EN
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    assign src = sync2_q;
`else
    assign src = in;
`endif

    logic [CHANNELS-1:0] s_q;
    logic [CHANNELS-1:0] s_prev_q;
    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] out_d;
    logic [CHANNELS-1:0] sticky_q;
    logic [CHANNELS-1:0] sticky_d;
    logic [BITS-1:0]     cnt_q [CHANNELS];
    logic [BITS-1:0]     cnt_d [CHANNELS];
    logic [CHANNELS-1:0] rise;
    logic [BITS-1:0]     hold_m1;

    assign rise    = s_q & ~s_prev_q;
    assign hold_m1 = (hold == '0) ? '0 : hold - BITS'(1);

    always_comb begin
        out_d = s_q;
        cnt_d = cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rise[i] && (cnt_q[i] == '0 || RETRIGGER != 0)) begin
                out_d[i] = 1'b1;
                cnt_d[i] = hold_m1;
            end else if (cnt_q[i] != '0) begin
                out_d[i] = 1'b1;
                cnt_d[i] = cnt_q[i] - BITS'(1);
            end
        end
    end

    // A new edge in the clearing cycle keeps its flag
    assign sticky_d = (sticky_q & ~{CHANNELS{clear}}) | rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q      <= '0;
            s_prev_q <= '0;
            out_q    <= '0;
            sticky_q <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            s_q      <= src;
            s_prev_q <= s_q;
            out_q    <= out_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out        = out_q;
    assign sticky     = sticky_q;
    assign any_active = |out_q;

endmodule

// File: tb/tb_pulse_stretcher_bank.sv
// Scoreboard bench: expected pulses (start cycle, length) are queued at stimulus
// time and matched against pulses observed on out of a retrigger and a non-retrigger bank.
module tb_pulse_stretcher_bank;

`ifdef PULSE_STRETCHER_BANK_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] in_v  = '0;
    logic [7:0] hold  = '0;
    logic [3:0] out_a, out_b, st_a, st_b;
    logic       act_a, act_b;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int d;
        int ch;
        int start;
        int len;
    } exp_t;

    exp_t exp_q[$];
    int   run[2][4];
    int   st[2][4];

    pulse_stretcher_bank #(.CHANNELS(4), .BITS(8), .RETRIGGER(1)) dut_a (
        .clk(clk), .reset(reset), .in(in_v), .hold(hold), .clear(clear),
        .out(out_a), .sticky(st_a), .any_active(act_a)
    );

    pulse_stretcher_bank #(.CHANNELS(4), .BITS(8), .RETRIGGER(0)) dut_b (
        .clk(clk), .reset(reset), .in(in_v), .hold(hold), .clear(clear),
        .out(out_b), .sticky(st_b), .any_active(act_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int ch, input int start,
                                input int len_a, input int len_b);
        exp_q.push_back('{0, ch, start, len_a});
        exp_q.push_back('{1, ch, start, len_b});
    endtask

    task automatic pulse_done(input int d, input int c, input int s, input int l);
        int idx;
        idx = -1;
        foreach (exp_q[k])
            if (idx < 0 && exp_q[k].d == d && exp_q[k].ch == c) idx = k;
        if (idx < 0) begin
            chk($sformatf("unexpected pulse dut%0d ch%0d len", d, c), l, 0);
        end else begin
            chk($sformatf("start dut%0d ch%0d", d, c), s, exp_q[idx].start);
            chk($sformatf("len dut%0d ch%0d", d, c), l, exp_q[idx].len);
            exp_q.delete(idx);
        end
    endtask

    // Pulse monitor: measures start cycle and length of every out pulse
    initial begin
        foreach (run[d, c]) begin
            run[d][c] = 0;
            st[d][c]  = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) begin
                    logic v;
                    v = (d == 0) ? out_a[c] : out_b[c];
                    if (v) begin
                        if (run[d][c] == 0) st[d][c] = cyc;
                        run[d][c]++;
                    end else if (run[d][c] != 0) begin
                        pulse_done(d, c, st[d][c], run[d][c]);
                        run[d][c] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int n;
        reset = 1'b1;
        tick;
        tick;
        chk("reset out_a", out_a, 0);
        chk("reset sticky_a", st_a, 0);
        chk("reset active_a", act_a, 0);
        chk("reset out_b", out_b, 0);
        chk("reset active_b", act_b, 0);
        reset = 1'b0;
        tick;

        // 1-cycle pulse, hold=5
        hold = 8'd5;
        s = cyc + LAT;
        in_v[0] = 1'b1;
        expect_pulse(0, s, 5, 5);
        tick;
        in_v[0] = 1'b0;
        repeat (LAT) tick;
        chk("active_a mid", act_a, 1);
        chk("active_b mid", act_b, 1);
        chk("sticky_a ch0", st_a, 4'b0001);
        repeat (15) tick;
        chk("active_a idle", act_a, 0);

        // input longer than hold
        s = cyc + LAT;
        in_v[1] = 1'b1;
        expect_pulse(1, s, 12, 12);
        repeat (12) tick;
        in_v[1] = 1'b0;
        repeat (20) tick;

        // hold=0 follows input
        hold = 8'd0;
        s = cyc + LAT;
        in_v[3] = 1'b1;
        expect_pulse(3, s, 3, 3);
        repeat (3) tick;
        in_v[3] = 1'b0;
        repeat (10) tick;
        chk("sticky_a 1011", st_a, 4'b1011);
        chk("sticky_b 1011", st_b, 4'b1011);

        // clear coinciding with a ch2 edge
        hold = 8'd5;
        s = cyc + LAT;
        in_v[2] = 1'b1;
        expect_pulse(2, s, 5, 5);
        tick;
        in_v[2] = 1'b0;
        repeat (LAT - 2) tick;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("sticky_a clr+set", st_a, 4'b0100);
        chk("sticky_b clr+set", st_b, 4'b0100);
        repeat (15) tick;

        // retrigger: pulses at t=0 and t=3
        s = cyc + LAT;
        in_v[0] = 1'b1;
        expect_pulse(0, s, 8, 5);
        tick;
        in_v[0] = 1'b0;
        tick;
        tick;
        in_v[0] = 1'b1;
        tick;
        in_v[0] = 1'b0;
        repeat (20) tick;

        // hold changed after load has no effect
        s = cyc + LAT;
        in_v[1] = 1'b1;
        expect_pulse(1, s, 5, 5);
        tick;
        in_v[1] = 1'b0;
        repeat (LAT - 1) tick;
        hold = 8'd2;
        repeat (15) tick;

        // simultaneous edges on all channels
        hold = 8'd3;
        s = cyc + LAT;
        in_v = 4'hf;
        for (int c = 0; c < 4; c++) expect_pulse(c, s, 3, 3);
        tick;
        in_v = 4'h0;
        repeat (12) tick;
        chk("sticky_a all", st_a, 4'hf);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("sticky_a cleared", st_a, 0);
        chk("sticky_b cleared", st_b, 0);

        // reset in the 10th stretch cycle, input stays high
        hold = 8'd200;
        n = cyc;
        in_v[2] = 1'b1;
        expect_pulse(2, n + LAT, 10, 10);
        while (cyc < n + LAT + 9) tick;
        #1;
        reset = 1'b1;
        #1;
        chk("mid-reset out_a", out_a, 0);
        chk("mid-reset active_a", act_a, 0);
        chk("mid-reset out_b", out_b, 0);
        chk("mid-reset active_b", act_b, 0);
        chk("mid-reset sticky_a", st_a, 0);
        tick;
        reset = 1'b0;
        expect_pulse(2, cyc + LAT, 200, 200);
        repeat (50) tick;
        in_v[2] = 1'b0;
        repeat (200) tick;
        chk("final active_a", act_a, 0);

        foreach (exp_q[k])
            chk($sformatf("missing pulse dut%0d ch%0d len", exp_q[k].d, exp_q[k].ch),
                0, exp_q[k].len);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
